// File: rtl/psum_acc_pkg.sv
// Shared psum_accumulator definitions: frame state, output conversion, width checks.
// Define PSUM_ACC_SATURATE_EN to clamp converted sums; otherwise they wrap.
package psum_acc_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_ACCUM = 1'b1} state_t;

  localparam int CONV_W     = 64;
  localparam int MIN_DATA_W = 1;

  function automatic bit widths_ok(input int w_in, input int w_acc, input int w_out);
    return (w_in >= MIN_DATA_W) && (w_out >= MIN_DATA_W) &&
           (w_acc >= w_in) && (w_out <= w_acc) && (w_acc <= CONV_W);
  endfunction

  // Result is sign-extended to CONV_W; callers keep the low w_out bits.
  function automatic logic signed [CONV_W-1:0] convert(input logic signed [CONV_W-1:0] acc,
                                                       input int w_out);
    logic signed [CONV_W-1:0] res;
`ifdef PSUM_ACC_SATURATE_EN
    logic signed [CONV_W-1:0] max_v;
    logic signed [CONV_W-1:0] min_v;
    max_v = (64'sd1 <<< (w_out - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (acc > max_v) begin
      res = max_v;
    end else if (acc < min_v) begin
      res = min_v;
    end else begin
      res = acc;
    end
`else
    res = (acc <<< (CONV_W - w_out)) >>> (CONV_W - w_out);
`endif
    return res;
  endfunction

endpackage

// File: rtl/psum_acc_lane.sv
// One lane: wrapping accumulator, output conversion and a registered result slot.
// Result appears the cycle after the frame's last beat and holds until its own handshake.
module psum_acc_lane
  import psum_acc_pkg::*;
#(
  parameter int DW_IN  = 16,
  parameter int DW_ACC = 24,
  parameter int DW_OUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_accept,
  input  logic                    i_last,
  input  logic signed [DW_IN-1:0] i_data,
  input  logic                    i_m_tready,
  output logic                    o_m_tvalid,
  output logic [DW_OUT-1:0]       o_m_tdata
);

  logic signed [DW_ACC-1:0] r_acc;
  logic signed [DW_ACC-1:0] w_acc_next;
  logic [DW_OUT-1:0]        w_conv;
  logic                     r_tvalid;
  logic [DW_OUT-1:0]        r_tdata;

  assign w_acc_next = r_acc + DW_ACC'(i_data);
  assign w_conv     = DW_OUT'(convert(CONV_W'(w_acc_next), DW_OUT));

  // A drain and a new load may land in the same cycle; the load wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
    end else begin
      if (r_tvalid && i_m_tready) begin
        r_tvalid <= 1'b0;
      end
      if (i_accept) begin
        if (i_last) begin
          r_acc    <= '0;
          r_tdata  <= w_conv;
          r_tvalid <= 1'b1;
        end else begin
          r_acc <= w_acc_next;
        end
      end
    end
  end

  assign o_m_tvalid = r_tvalid;
  assign o_m_tdata  = r_tdata;

endmodule

// File: rtl/psum_accumulator.sv
// Lock-step partial-sum accumulator: one result per lane per frame, 1 cycle after the last beat.
// Inputs stall together while any lane still holds an undrained result. Option: PSUM_ACC_SATURATE_EN.
module psum_accumulator
  import psum_acc_pkg::*;
#(
  parameter int LANES          = 1,
  parameter int DATA_WIDTH_IN  = 16,
  parameter int DATA_WIDTH_ACC = 24,
  parameter int DATA_WIDTH_OUT = 16,
  parameter int ID_WIDTH       = 1,
  parameter int DEST_WIDTH     = 1,
  parameter int USER_WIDTH     = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [LANES*DATA_WIDTH_IN-1:0]  s_axis_tdata,
  input  logic [LANES-1:0]                s_axis_tvalid,
  output logic [LANES-1:0]                s_axis_tready,
  input  logic [LANES-1:0]                s_axis_tlast,
  input  logic [LANES*ID_WIDTH-1:0]       s_axis_tid,
  input  logic [LANES*DEST_WIDTH-1:0]     s_axis_tdest,
  input  logic [LANES*USER_WIDTH-1:0]     s_axis_tuser,
  output logic [LANES*DATA_WIDTH_OUT-1:0] m_axis_tdata,
  output logic [LANES-1:0]                m_axis_tvalid,
  input  logic [LANES-1:0]                m_axis_tready,
  output logic [LANES-1:0]                m_axis_tlast,
  output logic [LANES*ID_WIDTH-1:0]       m_axis_tid,
  output logic [LANES*DEST_WIDTH-1:0]     m_axis_tdest,
  output logic [LANES*USER_WIDTH-1:0]     m_axis_tuser,
  output logic                            err_unaligned_data
);

  if (!widths_ok(DATA_WIDTH_IN, DATA_WIDTH_ACC, DATA_WIDTH_OUT)) begin : g_bad_widths
    $error("psum_accumulator: illegal DATA_WIDTH_IN/ACC/OUT combination");
  end

  state_t                        r_state;
  state_t                        w_state_next;
  logic [LANES-1:0]              w_lane_vld;
  logic                          w_all_vld;
  logic                          w_out_free;
  logic                          w_accept;
  logic                          w_last;
  logic                          w_unaligned;
  logic                          r_err;
  logic [LANES*ID_WIDTH-1:0]     r_tid;
  logic [LANES*DEST_WIDTH-1:0]   r_tdest;
  logic [LANES*USER_WIDTH-1:0]   r_tuser;

  assign w_all_vld   = &s_axis_tvalid;
  assign w_out_free  = &(~w_lane_vld | m_axis_tready);
  assign w_accept    = w_all_vld && w_out_free && !rst;
  assign w_last      = s_axis_tlast[0];
  assign w_unaligned = (s_axis_tlast != {LANES{w_last}});

  assign s_axis_tready = {LANES{w_accept}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Lane 0's tlast alone delimits the frame, also when other lanes disagree.
  always_comb begin
    w_state_next = r_state;
    if (w_accept) begin
      w_state_next = w_last ? ST_IDLE : ST_ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err   <= 1'b0;
      r_tid   <= '0;
      r_tdest <= '0;
      r_tuser <= '0;
    end else begin
      if (w_accept && w_unaligned) begin
        r_err <= 1'b1;
      end
      if (w_accept && w_last) begin
        r_tid   <= s_axis_tid;
        r_tdest <= s_axis_tdest;
        r_tuser <= s_axis_tuser;
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    psum_acc_lane #(
      .DW_IN (DATA_WIDTH_IN),
      .DW_ACC(DATA_WIDTH_ACC),
      .DW_OUT(DATA_WIDTH_OUT)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .i_accept  (w_accept),
      .i_last    (w_last),
      .i_data    (s_axis_tdata[k*DATA_WIDTH_IN +: DATA_WIDTH_IN]),
      .i_m_tready(m_axis_tready[k]),
      .o_m_tvalid(w_lane_vld[k]),
      .o_m_tdata (m_axis_tdata[k*DATA_WIDTH_OUT +: DATA_WIDTH_OUT])
    );
  end

  assign m_axis_tvalid      = w_lane_vld;
  assign m_axis_tlast       = w_lane_vld;
  assign m_axis_tid         = r_tid;
  assign m_axis_tdest       = r_tdest;
  assign m_axis_tuser       = r_tuser;
  assign err_unaligned_data = r_err;

endmodule
